// File: rtl/cmp_bist_sequencer.sv
// Built-in self-test sequencer for the magnitude comparator: sweeps every A/B pair,
// waits a settle interval, checks gt/eq/lt against a golden compare and reports the outcome.
module cmp_bist_sequencer #(
    parameter int W      = 2,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   a_out,
    output logic [W-1:0]   b_out,
    input  logic           gt_in,
    input  logic           eq_in,
    input  logic           lt_in,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*W:0]   err_count,
    output logic           fail_valid,
    output logic [W-1:0]   fail_a,
    output logic [W-1:0]   fail_b
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t       state;
    logic [3:0]   settle_cnt;
    logic [2:0]   golden;
    logic         mismatch;
    logic [2*W:0] err_next;
    logic         last_vec;

    // NOTE: every variable gets a value on every pass through always_comb, so no latch is inferred.
    always_comb begin
        golden   = {a_out > b_out, a_out == b_out, a_out < b_out};
        mismatch = (golden != {gt_in, eq_in, lt_in});
        err_next = err_count + (2*W+1)'(mismatch);
        last_vec = &{a_out, b_out};
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and wins over any launch or sweep activity on the same edge.
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            a_out      <= '0;
            b_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_out      <= '0;
                        b_out      <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt != '0)
                        settle_cnt <= settle_cnt - 4'd1;
                    else
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_a     <= a_out;
                        fail_b     <= b_out;
                    end
                    if (last_vec) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= S_DONE;
                    end else begin
                        // B is the fast index, so the pair advances as one 2W-bit counter.
                        {a_out, b_out} <= {a_out, b_out} + (2*W)'(1);
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_bist_sequencer.sv
// Self-checking bench for cmp_bist_sequencer: comparator models with injected faults,
// sweep results scoreboarded at launch and compared when done rises.
module tb_cmp_bist_sequencer;

    typedef struct {
        int err;
        bit pass;
        bit fv;
        int fa;
        int fb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] a_out, b_out, fail_a, fail_b;
    logic       gt_in, eq_in, lt_in;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;

    logic       start3;
    logic [2:0] a3, b3, fa3, fb3;
    logic       gt3, eq3, lt3;
    logic       busy3, done3, pass3, fv3;
    logic [6:0] err3;

    int   mode;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cmp_bist_sequencer #(.W(2), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out),
        .gt_in(gt_in), .eq_in(eq_in), .lt_in(lt_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
    );

    cmp_bist_sequencer #(.W(3), .SETTLE(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .a_out(a3), .b_out(b3),
        .gt_in(gt3), .eq_in(eq3), .lt_in(lt3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3)
    );

    // Comparator model: 0 = correct, 1 = eq stuck at 0, 2 = gt/lt swapped.
    always_comb begin
        gt_in = (a_out > b_out);
        eq_in = (a_out == b_out);
        lt_in = (a_out < b_out);
        if (mode == 1) begin
            eq_in = 1'b0;
        end else if (mode == 2) begin
            gt_in = (a_out < b_out);
            lt_in = (a_out > b_out);
        end
    end

    always_comb begin
        gt3 = (a3 > b3);
        eq3 = (a3 == b3);
        lt3 = (a3 < b3);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t expect_sweep(input int m);
        exp_t e;
        bit   bad;
        e = '{err: 0, pass: 1'b0, fv: 1'b0, fa: 0, fb: 0};
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                bad = (m == 1) ? (a == b) : (m == 2) ? (a != b) : 1'b0;
                if (bad) begin
                    if (!e.fv) begin
                        e.fv = 1'b1;
                        e.fa = a;
                        e.fb = b;
                    end
                    e.err++;
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic launch();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(expect_sweep(mode));
    endtask

    // Steps edges after a launch, checking vector order and busy, until done, stop_at or timeout.
    task automatic run_w2(input int stop_at, input int p1, input int p2, output int done_edge);
        int idx;
        done_edge = -1;
        for (int k = 1; k <= 60; k++) begin
            start = (k == p1) || (k == p2);
            @(posedge clk);
            #1;
            if (done) begin
                done_edge = k;
                break;
            end
            idx = k / 3;
            check("vec", 32'({a_out, b_out}), 32'(idx));
            check("busy", 32'(busy), 32'd1);
            if (k == stop_at) break;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_err"},   32'(err_count),  32'(e.err));
            check({tag, "_pass"},  32'(pass),       32'(e.pass));
            check({tag, "_fv"},    32'(fail_valid), 32'(e.fv));
            check({tag, "_fa"},    32'(fail_a),     32'(e.fa));
            check({tag, "_fb"},    32'(fail_b),     32'(e.fb));
            check({tag, "_busy"},  32'(busy),       32'd0);
            check({tag, "_done"},  32'(done),       32'd1);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"},    32'(a_out),      32'd0);
        check({tag, "_b"},    32'(b_out),      32'd0);
        check({tag, "_busy"}, 32'(busy),       32'd0);
        check({tag, "_done"}, 32'(done),       32'd0);
        check({tag, "_pass"}, 32'(pass),       32'd0);
        check({tag, "_err"},  32'(err_count),  32'd0);
        check({tag, "_fv"},   32'(fail_valid), 32'd0);
        check({tag, "_fa"},   32'(fail_a),     32'd0);
        check({tag, "_fb"},   32'(fail_b),     32'd0);
    endtask

    initial begin
        int de;
        rst    = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        check("reset3_busy", 32'(busy3), 32'd0);
        check("reset3_err",  32'(err3),  32'd0);
        check("reset3_ab",   32'({a3, b3}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: correct comparator
        mode = 0;
        launch();
        run_w2(0, 0, 0, de);
        check("t1_done_edge", 32'(de), 32'd48);
        check_result("t1");
        check("t1_final_ab", 32'({a_out, b_out}), 32'hF);

        // 2: eq stuck at 0
        mode = 1;
        launch();
        run_w2(0, 0, 0, de);
        check("t2_done_edge", 32'(de), 32'd48);
        check_result("t2");

        // 3: gt/lt swapped
        mode = 2;
        launch();
        run_w2(0, 0, 0, de);
        check("t3_done_edge", 32'(de), 32'd48);
        check_result("t3");

        // 4: reset mid-sweep at cycle 20, then a clean sweep
        mode = 0;
        launch();
        run_w2(19, 0, 0, de);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check_zero("t4_rst");
        repeat (3) @(posedge clk);
        #1;
        check_zero("t4_idle");
        launch();
        run_w2(0, 0, 0, de);
        check("t4_done_edge", 32'(de), 32'd48);
        check_result("t4");

        // 5: start pulses mid-sweep are ignored; start held in DONE relaunches
        mode = 2;
        launch();
        run_w2(0, 5, 30, de);
        check("t5_done_edge", 32'(de), 32'd48);
        check_result("t5");
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(expect_sweep(mode));
        check("t5_rs_done", 32'(done),       32'd0);
        check("t5_rs_busy", 32'(busy),       32'd1);
        check("t5_rs_ab",   32'({a_out, b_out}), 32'd0);
        check("t5_rs_err",  32'(err_count),  32'd0);
        check("t5_rs_fv",   32'(fail_valid), 32'd0);
        run_w2(0, 0, 0, de);
        check("t5_rs_done_edge", 32'(de), 32'd48);
        check_result("t5_rs");

        // 6: W=3, SETTLE=1 instance
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        de = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done3) begin
                de = k;
                break;
            end
            check("t6_vec", 32'({a3, b3}), 32'(k / 2));
        end
        check("t6_done_edge", 32'(de), 32'd128);
        check("t6_pass",  32'(pass3), 32'd1);
        check("t6_err",   32'(err3),  32'd0);
        check("t6_fv",    32'(fv3),   32'd0);
        check("t6_busy",  32'(busy3), 32'd0);
        check("t6_final", 32'({a3, b3}), 32'h3F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
